rr_arbiter_fsm: RTL and testbench

RR_ARBITER_FSM -- requirements
Module: rr_arbiter_fsm

---
 rtl/rr_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 26 ++
 rtl/rr_arbiter_fsm.sv | 95 +++++++++
 tb/tb_rr_arbiter_fsm.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and default sizing.
package rr_arb_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StGrant   = 2'd1,
        StRecover = 2'd2
    } rr_state_t;

    localparam int unsigned DEF_N        = 4;
    localparam int unsigned DEF_MAX_HOLD = 8;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: first set bit of req starting at ptr, wrapping modulo N.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int unsigned N = DEF_N,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    // Walk offsets from farthest to nearest so the nearest set bit is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                found = 1'b1;
                idx   = W'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_fsm.sv
// Round-robin arbiter with per-owner hold limit, release input and a recovery gap
// between consecutive grants. All outputs are registered.
module rr_arbiter_fsm
    import rr_arb_pkg::*;
#(
    parameter int unsigned N        = DEF_N,
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 rel,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic                 timeout
);

    localparam int unsigned W  = $clog2(N);
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    rr_state_t       r_state;
    logic [W-1:0]    r_ptr;
    logic [HW-1:0]   r_hold;
    logic [N-1:0]    r_gnt;
    logic [W-1:0]    r_owner;
    logic            r_busy;
    logic            r_timeout;

    logic            w_found;
    logic [W-1:0]    w_idx;
    logic            w_expire;
    logic            w_owner_req;
    logic            w_end;

    rr_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    assign w_expire    = (r_hold == HW'(MAX_HOLD));
    assign w_owner_req = req[r_owner];
    assign w_end       = rel | ~w_owner_req | w_expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_gnt     <= '0;
            r_owner   <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            unique case (r_state)
                StIdle, StRecover: begin
                    if (w_found) begin
                        r_state <= StGrant;
                        r_gnt   <= N'(1) << w_idx;
                        r_owner <= w_idx;
                        r_busy  <= 1'b1;
                        r_hold  <= HW'(1);
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StGrant: begin
                    if (w_end) begin
                        r_state   <= StRecover;
                        r_gnt     <= '0;
                        r_busy    <= 1'b0;
                        r_ptr     <= (r_owner == W'(N - 1)) ? '0 : r_owner + 1'b1;
                        // Release or a dropped request take precedence over expiry.
                        r_timeout <= w_expire & ~rel & w_owner_req;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign owner   = r_owner;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Directed bench for rr_arbiter_fsm: default N=4/MAX_HOLD=8 instance plus an N=2/MAX_HOLD=1 one.
module tb_rr_arbiter_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       rel;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;

    logic [1:0] req1;
    logic       rel1;
    logic [1:0] gnt1;
    logic [0:0] owner1;
    logic       busy1;
    logic       timeout1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_arbiter_fsm #(
        .N        (4),
        .MAX_HOLD (8)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout)
    );

    rr_arbiter_fsm #(
        .N        (2),
        .MAX_HOLD (1)
    ) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .req     (req1),
        .rel     (rel1),
        .gnt     (gnt1),
        .owner   (owner1),
        .busy    (busy1),
        .timeout (timeout1)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_g;
        rst  = 1'b1;
        req  = 4'b0000;
        rel  = 1'b0;
        req1 = 2'b00;
        rel1 = 1'b0;
        cyc();
        cyc();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);

        // First grant one cycle after req sampled in IDLE
        rst = 1'b0;
        req = 4'b1010;
        cyc();
        chk("g1_gnt", 32'(gnt), 32'h2);
        chk("g1_owner", 32'(owner), 32'h1);
        chk("g1_busy", 32'(busy), 32'h1);

        // Release in third grant cycle
        cyc();
        cyc();
        rel = 1'b1;
        cyc();
        rel = 1'b0;
        chk("rel_rec_gnt", 32'(gnt), 32'h0);
        chk("rel_rec_busy", 32'(busy), 32'h0);
        chk("rel_rec_timeout", 32'(timeout), 32'h0);
        cyc();
        chk("rel_next_gnt", 32'(gnt), 32'h8);
        chk("rel_next_owner", 32'(owner), 32'h3);

        // Non-owner req change keeps the grant
        req = 4'b1011;
        cyc();
        chk("nonowner_gnt", 32'(gnt), 32'h8);
        chk("nonowner_owner", 32'(owner), 32'h3);

        // Owner drops req -> grant ends
        req = 4'b0011;
        cyc();
        chk("drop_gnt", 32'(gnt), 32'h0);
        chk("drop_timeout", 32'(timeout), 32'h0);
        req = 4'b0000;
        cyc();
        chk("idle_gnt", 32'(gnt), 32'h0);

        // Expiry: 8 grant cycles, timeout in RECOVER, re-grant one cycle later
        req = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("exp_hold_gnt", 32'(gnt), 32'h1);
        end
        cyc();
        chk("exp_rec_gnt", 32'(gnt), 32'h0);
        chk("exp_rec_timeout", 32'(timeout), 32'h1);
        cyc();
        chk("exp_regrant_gnt", 32'(gnt), 32'h1);
        chk("exp_regrant_timeout", 32'(timeout), 32'h0);

        // rel coincident with expiry: no timeout
        for (int i = 0; i < 7; i++) cyc();
        chk("relexp_last_gnt", 32'(gnt), 32'h1);
        rel = 1'b1;
        cyc();
        rel = 1'b0;
        chk("relexp_gnt", 32'(gnt), 32'h0);
        chk("relexp_timeout", 32'(timeout), 32'h0);
        req = 4'b0000;
        cyc();

        // Reset mid-grant of owner 2
        req = 4'b0100;
        cyc();
        chk("g2_gnt", 32'(gnt), 32'h4);
        chk("g2_owner", 32'(owner), 32'h2);
        cyc();
        rst = 1'b1;
        req = 4'b1111;
        cyc();
        rst = 1'b0;
        chk("midrst_gnt", 32'(gnt), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_timeout", 32'(timeout), 32'h0);
        cyc();
        chk("postrst_gnt", 32'(gnt), 32'h1);
        chk("postrst_owner", 32'(owner), 32'h0);

        // All requesting for 40 cycles: 8 grant + 1 recover per owner, order 0,1,2,3,0
        for (int t = 0; t < 40; t++) begin
            exp_g = ((t % 9) < 8) ? (4'b0001 << ((t / 9) % 4)) : 4'b0000;
            chk("rr_gnt", 32'(gnt), 32'(exp_g));
            cyc();
        end
        req = 4'b0000;

        // MAX_HOLD=1: one grant cycle then one RECOVER cycle, alternating owners
        req1 = 2'b11;
        cyc();
        chk("mh1_g0", 32'(gnt1), 32'h1);
        cyc();
        chk("mh1_r0_gnt", 32'(gnt1), 32'h0);
        chk("mh1_r0_timeout", 32'(timeout1), 32'h1);
        cyc();
        chk("mh1_g1", 32'(gnt1), 32'h2);
        chk("mh1_g1_owner", 32'(owner1), 32'h1);
        cyc();
        chk("mh1_r1_gnt", 32'(gnt1), 32'h0);
        cyc();
        chk("mh1_g2", 32'(gnt1), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
